// File: rtl/ctrl_delay_pipe_if.sv
// ctrl_delay_pipe_if: bundles the control-word pipeline's input and tap signals.
//   master : decode side. It drives in_ctrl, in_valid, stall and flush, and it
//            observes in_ready and every stage tap.
//   slave  : the pipeline itself (ctrl_delay_pipe).
// Signals:
//   in_ctrl     [WIDTH]        control word from decode
//   in_valid                   in_ctrl is a real instruction
//   stall                      freeze the front stages
//   flush                      kill the front stages
//   in_ready                   in_ctrl is captured when in_valid && in_ready
//   stage_ctrl  [DEPTH*WIDTH]  stage i word at [i*WIDTH +: WIDTH]
//   stage_valid [DEPTH]        per-stage valid bit
//   out_ctrl / out_valid       last stage word and its valid bit
//   occupancy   [clog2(DEPTH+1)] number of valid stages
interface ctrl_delay_pipe_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]       in_ctrl;
  logic                   in_valid;
  logic                   stall;
  logic                   flush;
  logic                   in_ready;
  logic [DEPTH*WIDTH-1:0] stage_ctrl;
  logic [DEPTH-1:0]       stage_valid;
  logic [WIDTH-1:0]       out_ctrl;
  logic                   out_valid;
  logic [OccW-1:0]        occupancy;

  modport master (
    output in_ctrl, in_valid, stall, flush,
    input  in_ready, stage_ctrl, stage_valid, out_ctrl, out_valid, occupancy
  );

  modport slave (
    input  in_ctrl, in_valid, stall, flush,
    output in_ready, stage_ctrl, stage_valid, out_ctrl, out_valid, occupancy
  );
endinterface

// File: rtl/ctrl_delay_pipe.sv
// ctrl_delay_pipe: a delay pipeline for decoded control words. It runs alongside the FP
// ALU datapath and taps every stage, so each datapath stage can pick up its controls.
// It supports per-stage valid bits, a partial stall with bubble insertion, a flush of the
// front stages and an occupancy count.
// Ports:
//   Clock  : clock. All state updates on the rising edge.
//   Reset  : synchronous, active-high. It clears every stage and wins over stall and flush.
//   pipe   : ctrl_delay_pipe_if.slave. Carries the input word and handshake, stall and
//            flush, and the registered stage taps plus occupancy.
// Stages 0..HOLD_STAGES-1 form the "front". A stall freezes the front. A flush kills the
// front. Stages at or past HOLD_STAGES always advance, so older instructions still
// complete.
module ctrl_delay_pipe #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_STAGES = 2
) (
  input logic              Clock,
  input logic              Reset,
  ctrl_delay_pipe_if.slave pipe
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  typedef logic [DEPTH-1:0][WIDTH-1:0] stageWords_t;

  stageWords_t      ctrlQ, ctrlD;
  stageWords_t      feedCtrl;
  logic [DEPTH-1:0] validQ, validD;
  logic [DEPTH-1:0] feedValid;
  logic [OccW-1:0]  occQ, occD;
  logic [WIDTH-1:0] inWord;

  // The input word is masked so that a non-valid slot never carries enables.
  assign inWord    = pipe.in_valid ? pipe.in_ctrl : '0;

  // This is the value each stage takes when it advances normally.
  assign feedCtrl  = {ctrlQ[DEPTH-2:0], inWord};
  assign feedValid = {validQ[DEPTH-2:0], pipe.in_valid};

  always_comb begin
    ctrlD  = feedCtrl;
    validD = feedValid;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i < HOLD_STAGES) begin
        if (pipe.flush) begin
          ctrlD[i]  = '0;
          validD[i] = 1'b0;
        end else if (pipe.stall) begin
          ctrlD[i]  = ctrlQ[i];
          validD[i] = validQ[i];
        end
      end else if (i == HOLD_STAGES && pipe.stall) begin
        // The first stage past the frozen front has no feeder this cycle, so it
        // takes a bubble.
        ctrlD[i]  = '0;
        validD[i] = 1'b0;
      end
    end
  end

  // Occupancy is computed from the next-state valids, so it changes on the same edge.
  always_comb begin
    occD = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occD = occD + OccW'(validD[i]);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ctrlQ  <= '0;
      validQ <= '0;
      occQ   <= '0;
    end else begin
      ctrlQ  <= ctrlD;
      validQ <= validD;
      occQ   <= occD;
    end
  end

  assign pipe.in_ready    = !pipe.stall && !pipe.flush;
  assign pipe.stage_ctrl  = ctrlQ;
  assign pipe.stage_valid = validQ;
  assign pipe.out_ctrl    = ctrlQ[DEPTH-1];
  assign pipe.out_valid   = validQ[DEPTH-1];
  assign pipe.occupancy   = occQ;

endmodule
